// File: rtl/audio_mixer_nch_pkg.sv
// Shared audio types and helpers: mixer FSM states, volume scaling, and a saturating clamp.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mixer_state_t;

    // Volume is in 256ths of full scale.
    localparam int VOL_UNITY_SHIFT = 8;

    typedef struct packed {
        logic        clipped;
        logic [63:0] val;
    } sat_res_t;

    // Clamp a wide accumulator to an in_w-bit sample range; val holds the
    // clamped value sign- or zero-extended to 64 bits.
    function automatic sat_res_t sat_clamp(
        input logic signed [63:0] acc,
        input int unsigned        in_w,
        input logic               is_signed
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        if (is_signed) begin
            hi = (64'sd1 <<< (in_w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (in_w - 1));
        end else begin
            hi = (64'sd1 <<< in_w) - 64'sd1;
            lo = 64'sd0;
        end
        r.clipped = 1'b0;
        r.val     = acc;
        if (acc > hi) begin
            r.val     = hi;
            r.clipped = 1'b1;
        end else if (acc < lo) begin
            r.val     = lo;
            r.clipped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_mixer_nch.sv
// N-channel stereo mixer: one shared multiply-accumulate per clock, result valid NUM_CH+1 cycles after strobe.
// No backpressure: strobes arriving while a mix is in flight are dropped and raise overrun_o.
module audio_mixer_nch #(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int IS_SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_strobe_i,
    input  logic [NUM_CH*IN_WIDTH-1:0] ch_sample_i,
    input  logic [NUM_CH*8-1:0]        ch_vol_i,
    input  logic [NUM_CH-1:0]          ch_route_l_i,
    input  logic [NUM_CH-1:0]          ch_route_r_i,
    input  logic                       mute_i,
    input  logic                       clear_flags_i,
    output logic [OUT_WIDTH-1:0]       audio_l_o,
    output logic [OUT_WIDTH-1:0]       audio_r_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       clip_l_o,
    output logic                       clip_r_o,
    output logic                       overrun_o
);
    import audio_pkg::*;

    localparam int ACC_W  = IN_WIDTH + 2 + $clog2(NUM_CH);
    localparam int PROD_W = IN_WIDTH + 10;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    mixer_state_t                state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]     acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]     acc_r_q, acc_r_d;
    logic [NUM_CH*IN_WIDTH-1:0]  sh_sample_q, sh_sample_d;
    logic [NUM_CH*8-1:0]         sh_vol_q, sh_vol_d;
    logic [NUM_CH-1:0]           sh_route_l_q, sh_route_l_d;
    logic [NUM_CH-1:0]           sh_route_r_q, sh_route_r_d;
    logic                        sh_mute_q, sh_mute_d;
    logic [OUT_WIDTH-1:0]        audio_l_q, audio_l_d;
    logic [OUT_WIDTH-1:0]        audio_r_q, audio_r_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        clip_l_q, clip_l_d;
    logic                        clip_r_q, clip_r_d;
    logic                        overrun_q, overrun_d;

    logic [IN_WIDTH-1:0]         samp;
    logic signed [IN_WIDTH:0]    samp_x;
    logic signed [8:0]           vol_x;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     term;
    sat_res_t                    sat_l;
    sat_res_t                    sat_r;

    // Shared multiplier datapath for the channel selected by idx_q.
    always_comb begin
        samp   = sh_sample_q[int'(idx_q)*IN_WIDTH +: IN_WIDTH];
        samp_x = (IS_SIGNED != 0) ? $signed({samp[IN_WIDTH-1], samp}) : $signed({1'b0, samp});
        vol_x  = $signed({1'b0, sh_vol_q[int'(idx_q)*8 +: 8]});
        prod   = PROD_W'(samp_x) * PROD_W'(vol_x);
        term   = ACC_W'(prod >>> VOL_UNITY_SHIFT);
        sat_l  = sat_clamp(64'(acc_l_q), IN_WIDTH, IS_SIGNED != 0);
        sat_r  = sat_clamp(64'(acc_r_q), IN_WIDTH, IS_SIGNED != 0);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        sh_sample_d  = sh_sample_q;
        sh_vol_d     = sh_vol_q;
        sh_route_l_d = sh_route_l_q;
        sh_route_r_d = sh_route_r_q;
        sh_mute_d    = sh_mute_q;
        audio_l_d    = audio_l_q;
        audio_r_d    = audio_r_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        // Clear first so any set below in the same cycle wins.
        clip_l_d     = clear_flags_i ? 1'b0 : clip_l_q;
        clip_r_d     = clear_flags_i ? 1'b0 : clip_r_q;
        overrun_d    = clear_flags_i ? 1'b0 : overrun_q;

        case (state_q)
            IDLE: begin
                if (sample_strobe_i) begin
                    sh_sample_d  = ch_sample_i;
                    sh_vol_d     = ch_vol_i;
                    sh_route_l_d = ch_route_l_i;
                    sh_route_r_d = ch_route_r_i;
                    sh_mute_d    = mute_i;
                    acc_l_d      = '0;
                    acc_r_d      = '0;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                if (sample_strobe_i) overrun_d = 1'b1;
                if (sh_route_l_q[idx_q]) acc_l_d = acc_l_q + term;
                if (sh_route_r_q[idx_q]) acc_r_d = acc_r_q + term;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_CH - 1)) state_d = SAT;
            end
            SAT: begin
                if (sample_strobe_i) overrun_d = 1'b1;
                if (sh_mute_q) begin
                    audio_l_d = '0;
                    audio_r_d = '0;
                end else begin
                    audio_l_d = OUT_WIDTH'(sat_l.val << (OUT_WIDTH - IN_WIDTH));
                    audio_r_d = OUT_WIDTH'(sat_r.val << (OUT_WIDTH - IN_WIDTH));
                    if (sat_l.clipped) clip_l_d = 1'b1;
                    if (sat_r.clipped) clip_r_d = 1'b1;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            sh_sample_q  <= '0;
            sh_vol_q     <= '0;
            sh_route_l_q <= '0;
            sh_route_r_q <= '0;
            sh_mute_q    <= 1'b0;
            audio_l_q    <= '0;
            audio_r_q    <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            clip_l_q     <= 1'b0;
            clip_r_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            sh_sample_q  <= sh_sample_d;
            sh_vol_q     <= sh_vol_d;
            sh_route_l_q <= sh_route_l_d;
            sh_route_r_q <= sh_route_r_d;
            sh_mute_q    <= sh_mute_d;
            audio_l_q    <= audio_l_d;
            audio_r_q    <= audio_r_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            clip_l_q     <= clip_l_d;
            clip_r_q     <= clip_r_d;
            overrun_q    <= overrun_d;
        end
    end

    assign audio_l_o = audio_l_q;
    assign audio_r_o = audio_r_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign clip_l_o  = clip_l_q;
    assign clip_r_o  = clip_r_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Bench for audio_mixer_nch: an unsigned and a signed instance share stimulus and are compared every cycle to an arithmetic model.
module tb_audio_mixer_nch;
    localparam int NCH = 4;
    localparam int W   = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           strobe;
    logic [63:0]    ch_sample;
    logic [31:0]    ch_vol;
    logic [3:0]     route_l, route_r;
    logic           mute, clear_flags;

    logic [15:0]    audio_l_u, audio_r_u, audio_l_s, audio_r_s;
    logic           valid_u, busy_u, clip_l_u, clip_r_u, ovr_u;
    logic           valid_s, busy_s, clip_l_s, clip_r_s, ovr_s;

    always #5 clk = ~clk;

    audio_mixer_nch #(.NUM_CH(NCH), .IN_WIDTH(W), .OUT_WIDTH(W), .IS_SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset), .sample_strobe_i(strobe), .ch_sample_i(ch_sample),
        .ch_vol_i(ch_vol), .ch_route_l_i(route_l), .ch_route_r_i(route_r),
        .mute_i(mute), .clear_flags_i(clear_flags),
        .audio_l_o(audio_l_u), .audio_r_o(audio_r_u), .valid_o(valid_u), .busy_o(busy_u),
        .clip_l_o(clip_l_u), .clip_r_o(clip_r_u), .overrun_o(ovr_u)
    );

    audio_mixer_nch #(.NUM_CH(NCH), .IN_WIDTH(W), .OUT_WIDTH(W), .IS_SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .sample_strobe_i(strobe), .ch_sample_i(ch_sample),
        .ch_vol_i(ch_vol), .ch_route_l_i(route_l), .ch_route_r_i(route_r),
        .mute_i(mute), .clear_flags_i(clear_flags),
        .audio_l_o(audio_l_s), .audio_r_o(audio_r_s), .valid_o(valid_s), .busy_o(busy_s),
        .clip_l_o(clip_l_s), .clip_r_o(clip_r_s), .overrun_o(ovr_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sum of floor(sample*vol/256) over the routed channels.
    function automatic longint mix_side(input logic [63:0] smp, input logic [31:0] vol,
                                        input logic [3:0] rt, input bit sgn);
        longint acc, s, v;
        acc = 0;
        for (int c = 0; c < NCH; c++) begin
            if (rt[c]) begin
                if (sgn) s = longint'($signed(smp[c*W +: W]));
                else     s = longint'({48'h0, smp[c*W +: W]});
                v = longint'({56'h0, vol[c*8 +: 8]});
                acc += (s * v) >>> 8;
            end
        end
        return acc;
    endfunction

    function automatic logic [15:0] clamp16(input longint acc, input bit sgn, output bit clip);
        longint hi, lo, r;
        hi = sgn ? 32767 : 65535;
        lo = sgn ? -32768 : 0;
        clip = 1'b0;
        r = acc;
        if (acc > hi) begin r = hi; clip = 1'b1; end
        else if (acc < lo) begin r = lo; clip = 1'b1; end
        return r[15:0];
    endfunction

    // Model: a countdown of cycles to the result, pending results taken at strobe time.
    int          m_rem;
    logic [15:0] p_lu, p_ru, p_ls, p_rs;
    bit          pc_lu, pc_ru, pc_ls, pc_rs, p_mute;
    logic [15:0] e_lu, e_ru, e_ls, e_rs;
    bit          e_clu, e_cru, e_cls, e_crs, e_ovr, e_vld;

    always @(posedge clk) begin
        bit was_busy;
        if (reset) begin
            m_rem = 0; e_vld = 0; e_ovr = 0;
            e_lu = '0; e_ru = '0; e_ls = '0; e_rs = '0;
            e_clu = 0; e_cru = 0; e_cls = 0; e_crs = 0;
        end else begin
            was_busy = (m_rem != 0);
            e_vld = 0;
            if (clear_flags) begin
                e_clu = 0; e_cru = 0; e_cls = 0; e_crs = 0; e_ovr = 0;
            end
            if (m_rem == 1) begin
                e_vld = 1;
                if (p_mute) begin
                    e_lu = '0; e_ru = '0; e_ls = '0; e_rs = '0;
                end else begin
                    e_lu = p_lu; e_ru = p_ru; e_ls = p_ls; e_rs = p_rs;
                    e_clu |= pc_lu; e_cru |= pc_ru; e_cls |= pc_ls; e_crs |= pc_rs;
                end
            end
            if (m_rem != 0) m_rem--;
            if (strobe) begin
                if (was_busy) e_ovr = 1;
                else begin
                    p_lu = clamp16(mix_side(ch_sample, ch_vol, route_l, 0), 0, pc_lu);
                    p_ru = clamp16(mix_side(ch_sample, ch_vol, route_r, 0), 0, pc_ru);
                    p_ls = clamp16(mix_side(ch_sample, ch_vol, route_l, 1), 1, pc_ls);
                    p_rs = clamp16(mix_side(ch_sample, ch_vol, route_r, 1), 1, pc_rs);
                    p_mute = mute;
                    m_rem = NCH + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_u", 64'(valid_u), 64'(e_vld));
            chk("valid_s", 64'(valid_s), 64'(e_vld));
            chk("busy_u", 64'(busy_u), 64'(m_rem != 0));
            chk("busy_s", 64'(busy_s), 64'(m_rem != 0));
            chk("overrun_u", 64'(ovr_u), 64'(e_ovr));
            chk("overrun_s", 64'(ovr_s), 64'(e_ovr));
            chk("clip_l_u", 64'(clip_l_u), 64'(e_clu));
            chk("clip_r_u", 64'(clip_r_u), 64'(e_cru));
            chk("clip_l_s", 64'(clip_l_s), 64'(e_cls));
            chk("clip_r_s", 64'(clip_r_s), 64'(e_crs));
            chk("audio_l_u", 64'(audio_l_u), 64'(e_lu));
            chk("audio_r_u", 64'(audio_r_u), 64'(e_ru));
            chk("audio_l_s", 64'(audio_l_s), 64'(e_ls));
            chk("audio_r_s", 64'(audio_r_s), 64'(e_rs));
        end
    end

    task automatic setup(input logic [63:0] s, input logic [31:0] v,
                         input logic [3:0] rl, input logic [3:0] rr, input logic m);
        ch_sample = s; ch_vol = v; route_l = rl; route_r = rr; mute = m;
    endtask

    task automatic run_mix(input string name);
        int lat;
        @(negedge clk); strobe = 1'b1;
        @(negedge clk); strobe = 1'b0;
        lat = 0;
        while (valid_u !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk(name, 64'(lat), 64'd5);
    endtask

    task automatic count_valids(input int cycles, output int n, output logic [15:0] l, output logic [15:0] r);
        n = 0; l = '0; r = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_u === 1'b1) begin
                n++; l = audio_l_u; r = audio_r_u;
            end
        end
    endtask

    initial begin
        int          nv;
        logic [15:0] cl, cr;
        reset = 1'b1; strobe = 1'b0; clear_flags = 1'b0;
        setup('0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_audio_l", 64'(audio_l_u), 64'h0);
        chk("reset_valid", 64'(valid_u), 64'h0);
        chk("reset_busy", 64'(busy_s), 64'h0);
        chk("reset_flags", 64'({clip_l_u, clip_r_u, ovr_u}), 64'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Single channel at half scale, volume 255, left only.
        setup({48'h0, 16'h8000}, {24'h0, 8'hFF}, 4'b0001, 4'b0000, 1'b0);
        run_mix("lat_t1");
        chk("t1_l_u", 64'(audio_l_u), 64'h7F80);
        chk("t1_r_u", 64'(audio_r_u), 64'h0);
        chk("t1_clip_u", 64'(clip_l_u), 64'h0);
        chk("t1_l_s", 64'(audio_l_s), 64'h8080);

        // Four full-scale channels into both sides.
        setup({4{16'hFFFF}}, {4{8'hFF}}, 4'hF, 4'hF, 1'b0);
        run_mix("lat_t2");
        chk("t2_l_u", 64'(audio_l_u), 64'hFFFF);
        chk("t2_r_u", 64'(audio_r_u), 64'hFFFF);
        chk("t2_clips_u", 64'({clip_l_u, clip_r_u}), 64'h3);
        chk("t2_l_s", 64'(audio_l_s), 64'hFFFC);
        @(negedge clk); clear_flags = 1'b1;
        @(negedge clk); clear_flags = 1'b0;
        chk("t2_cleared", 64'({clip_l_u, clip_r_u}), 64'h0);

        // Signed: +0x4000 and -0x6000.
        setup({32'h0, 16'hA000, 16'h4000}, {16'h0, 16'hFFFF}, 4'b0011, 4'b0000, 1'b0);
        run_mix("lat_t3");
        chk("t3_l_s", 64'(audio_l_s), 64'hE020);
        chk("t3_l_u", 64'(audio_l_u), 64'hDF20);

        // Second strobe two cycles in, inputs changed mid-mix.
        setup({48'h0, 16'h8000}, {24'h0, 8'hFF}, 4'b0001, 4'b0000, 1'b0);
        @(negedge clk); strobe = 1'b1;
        @(negedge clk); strobe = 1'b0;
        @(negedge clk); strobe = 1'b1;
        @(negedge clk); strobe = 1'b0;
        setup({4{16'hFFFF}}, {4{8'hFF}}, 4'hF, 4'hF, 1'b1);
        count_valids(12, nv, cl, cr);
        chk("t4_nvalid", 64'(nv), 64'd1);
        chk("t4_l", 64'(cl), 64'h7F80);
        chk("t4_r", 64'(cr), 64'h0);
        chk("t4_overrun", 64'(ovr_u), 64'h1);
        @(negedge clk); clear_flags = 1'b1;
        @(negedge clk); clear_flags = 1'b0;

        // Mute with clipping stimulus.
        setup({4{16'hFFFF}}, {4{8'hFF}}, 4'hF, 4'hF, 1'b1);
        run_mix("lat_t5");
        chk("t5_out", 64'({audio_l_u, audio_r_u}), 64'h0);
        chk("t5_clips", 64'({clip_l_u, clip_r_u}), 64'h0);

        // Clear held through a clipping mix: the new clip still lands.
        setup({4{16'hFFFF}}, {4{8'hFF}}, 4'hF, 4'hF, 1'b0);
        @(negedge clk); clear_flags = 1'b1;
        run_mix("lat_t7");
        chk("t7_set_wins", 64'({clip_l_u, clip_r_u}), 64'h3);
        @(negedge clk); clear_flags = 1'b0;

        // Reset while the accumulator is at channel 2.
        setup({32'h0, 16'hA000, 16'h4000}, {16'h0, 16'hFFFF}, 4'b0011, 4'b0000, 1'b0);
        @(negedge clk); strobe = 1'b1;
        @(negedge clk); strobe = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("t6_busy", 64'(busy_u), 64'h0);
        chk("t6_out", 64'({audio_l_u, audio_r_u}), 64'h0);
        chk("t6_flags", 64'({clip_l_u, clip_r_u}), 64'h0);
        count_valids(8, nv, cl, cr);
        chk("t6_no_valid", 64'(nv), 64'd0);
        run_mix("lat_t6");
        chk("t6_l_s", 64'(audio_l_s), 64'hE020);
        chk("t6_l_u", 64'(audio_l_u), 64'hDF20);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
